intr_controller: RTL and testbench

- External interrupt controller that sits directly upstream of the pipelined MIPS CPU and drives its External_intr input.
- Synchronises N asynchronous interrupt sources and turns their rising edges into sticky pending bits.
- Applies a CPU-writable mask and picks one fixed-priority winner.
- Holds a single-outstanding request/acknowledge/return handshake with the CPU exception logic, so only one interrupt is in service at a time.

---
 rtl/intr_controller_pkg.sv | 13 +
 rtl/intr_controller_if.sv | 28 ++
 rtl/intr_sync_edge.sv | 29 ++
 rtl/intr_controller.sv | 98 +++++++++
 tb/tb_intr_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_controller_pkg.sv
// rtl/intr_controller_pkg.sv - shared state encoding and reset constants for intr_controller
package intr_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } intr_state_e;

    // Wide enough for any supported N_SRC; the top slices off what it needs.
    localparam logic [31:0] MASK_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/intr_controller_if.sv
// rtl/intr_controller_if.sv - source/mask/CPU handshake bundle for intr_controller
// master: interrupt sources and CPU side (drives irq_src, mask write, ack/eret)
// slave : intr_controller (drives External_intr, intr_cause, mask_q, pending_q, in_service)
interface intr_controller_if #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 2
);
    logic [N_SRC-1:0]   irq_src;
    logic               mask_we;
    logic [N_SRC-1:0]   mask_wdata;
    logic               intr_ack;
    logic               intr_eret;
    logic               External_intr;
    logic [CAUSE_W-1:0] intr_cause;
    logic [N_SRC-1:0]   mask_q;
    logic [N_SRC-1:0]   pending_q;
    logic               in_service;

    modport master (
        output irq_src, mask_we, mask_wdata, intr_ack, intr_eret,
        input  External_intr, intr_cause, mask_q, pending_q, in_service
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, intr_ack, intr_eret,
        output External_intr, intr_cause, mask_q, pending_q, in_service
    );
endinterface

// File: rtl/intr_sync_edge.sv
// rtl/intr_sync_edge.sv - per-bit 2-flop synchroniser plus rising-edge detector
// Ports: clk, rst (sync, active-high), d (async lines), rise (one-cycle pulse per rising edge)
module intr_sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 is the history flop: a held level yields exactly one pulse.
    assign rise = s2 & ~s3;
endmodule

// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - edge-latched, masked, fixed-priority interrupt controller
// Ports: clk, rst (sync, active-high), bus (intr_controller_if.slave):
//   in : irq_src, mask_we, mask_wdata, intr_ack, intr_eret
//   out: External_intr, intr_cause, mask_q, pending_q, in_service
module intr_controller
    import intr_controller_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    intr_controller_if.slave bus
);
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   pending_r;
    logic [N_SRC-1:0]   mask_r;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   clr;
    logic [CAUSE_W-1:0] winner;
    logic [CAUSE_W-1:0] cause_r;
    logic               ext_r;
    logic               svc_r;
    intr_state_e        state;

    intr_sync_edge #(.W(N_SRC)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.irq_src),
        .rise (rise)
    );

    assign eligible = pending_r & mask_r;

    // Descending scan so the lowest set index is the last assignment and wins.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CAUSE_W'(i);
        end
    end

    // Only an ack that the FSM actually accepts may clear a pending bit.
    always_comb begin
        clr = '0;
        if (state == ST_REQ && bus.intr_ack) clr[cause_r] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ext_r     <= 1'b0;
            cause_r   <= '0;
            svc_r     <= 1'b0;
            pending_r <= '0;
            mask_r    <= MASK_RESET[N_SRC-1:0];
        end else begin
            // OR-ing rise after the clear makes a same-cycle re-edge win.
            pending_r <= (pending_r & ~clr) | rise;
            if (bus.mask_we) mask_r <= bus.mask_wdata;

            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        ext_r   <= 1'b1;
                        cause_r <= winner;
                        state   <= ST_REQ;
                    end
                end
                // Request is held even if masked meanwhile; only ack ends it.
                ST_REQ: begin
                    if (bus.intr_ack) begin
                        ext_r <= 1'b0;
                        svc_r <= 1'b1;
                        state <= ST_SVC;
                    end
                end
                ST_SVC: begin
                    if (bus.intr_eret) begin
                        svc_r <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ext_r <= 1'b0;
                    svc_r <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.External_intr = ext_r;
    assign bus.intr_cause    = cause_r;
    assign bus.mask_q        = mask_r;
    assign bus.pending_q     = pending_r;
    assign bus.in_service    = svc_r;
endmodule

// File: tb/tb_intr_controller.sv
// tb/tb_intr_controller.sv - self-checking bench for intr_controller
module tb_intr_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    intr_controller_if #(.N_SRC(4), .CAUSE_W(2)) bus ();

    intr_controller #(.N_SRC(4), .CAUSE_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: scheduled-event view of the controller.
    // A sampled rising edge becomes a pending bit two edges later; the
    // request/service handshake is a three-mode loop over that pending set.
    typedef struct {
        int         due;
        logic [3:0] v;
    } ev_t;
    ev_t        evq[$];
    int         cyc = 0;
    logic [3:0] m_prev, m_pend, m_mask, m_arr, m_clr, m_ev;
    int         m_mode, m_cause;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            evq.delete();
            m_prev = 4'h0; m_pend = 4'h0; m_mask = 4'hF;
            m_mode = 0; m_cause = 0;
        end else begin
            m_arr = 4'h0;
            while (evq.size() > 0 && evq[0].due == cyc) begin
                m_arr |= evq[0].v;
                void'(evq.pop_front());
            end
            m_clr = 4'h0;
            case (m_mode)
                0: if ((m_pend & m_mask) != 0) begin m_mode = 1; m_cause = lowest(m_pend & m_mask); end
                1: if (bus.intr_ack) begin m_clr = 4'(1 << m_cause); m_mode = 2; end
                default: if (bus.intr_eret) m_mode = 0;
            endcase
            m_pend = (m_pend & ~m_clr) | m_arr;
            if (bus.mask_we) m_mask = bus.mask_wdata;
            m_ev = bus.irq_src & ~m_prev;
            m_prev = bus.irq_src;
            if (m_ev != 0) evq.push_back('{cyc + 2, m_ev});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        bus.intr_ack = 1'b1; tick(); bus.intr_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.intr_eret = 1'b1; tick(); bus.intr_eret = 1'b0;
    endtask

    task automatic pulse_src(input logic [3:0] v);
        bus.irq_src = v; tick(); bus.irq_src = 4'h0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !bus.External_intr; i++) tick();
        n_cmp++;
        if (bus.External_intr !== 1'b1) begin
            n_bad++; $display("FAIL %s_req_timeout: External_intr=%b expected 1", tag, bus.External_intr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service} !== {1'b0, 2'd0, 4'hF, 4'h0, 1'b0}) begin
            n_bad++; $display("FAIL reset_values: ext=%b cause=%0d mask=%h pend=%h svc=%b expected 0 0 f 0 0",
                bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service);
        end
    endtask

    task automatic test_latency();
        bus.irq_src = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.External_intr !== (i == 3)) begin
                n_bad++; $display("FAIL latency_edge%0d: External_intr=%b expected %b", i, bus.External_intr, (i == 3));
            end
        end
        n_cmp++;
        if (bus.intr_cause !== 2'd2) begin n_bad++; $display("FAIL latency_cause: got %0d expected 2", bus.intr_cause); end
        pulse_ack();
        n_cmp++;
        if ({bus.pending_q, bus.in_service, bus.External_intr} !== {4'h0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL latency_ack: pend=%h svc=%b ext=%b expected 0 1 0", bus.pending_q, bus.in_service, bus.External_intr);
        end
        tick();
        pulse_eret();
        n_cmp++;
        if (bus.in_service !== 1'b0) begin n_bad++; $display("FAIL latency_eret: in_service=%b expected 0", bus.in_service); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (bus.External_intr !== 1'b0) begin n_bad++; $display("FAIL held_level_rerequest: cycle %0d ext=%b expected 0", i, bus.External_intr); end
        end
        bus.irq_src = 4'h0;
        repeat (4) tick();
    endtask

    task automatic test_priority();
        pulse_src(4'b1010);
        wait_req("prio");
        n_cmp++;
        if (bus.intr_cause !== 2'd1) begin n_bad++; $display("FAIL prio_first: cause=%0d expected 1", bus.intr_cause); end
        pulse_ack(); tick(); pulse_eret();
        n_cmp++;
        if (bus.External_intr !== 1'b0) begin n_bad++; $display("FAIL prio_gap: ext=%b expected 0", bus.External_intr); end
        tick();
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause} !== {1'b1, 2'd3}) begin
            n_bad++; $display("FAIL prio_second: ext=%b cause=%0d expected 1 3", bus.External_intr, bus.intr_cause);
        end
        pulse_ack(); pulse_eret(); tick();
    endtask

    task automatic test_mask();
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1110; tick(); bus.mask_we = 1'b0;
        pulse_src(4'b0001);
        repeat (6) tick();
        n_cmp++;
        if ({bus.pending_q, bus.External_intr} !== {4'b0001, 1'b0}) begin
            n_bad++; $display("FAIL mask_block: pend=%h ext=%b expected 1 0", bus.pending_q, bus.External_intr);
        end
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111; tick(); bus.mask_we = 1'b0;
        n_cmp++;
        if ({bus.mask_q, bus.External_intr} !== {4'hF, 1'b0}) begin
            n_bad++; $display("FAIL mask_write: mask=%h ext=%b expected f 0", bus.mask_q, bus.External_intr);
        end
        tick();
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause} !== {1'b1, 2'd0}) begin
            n_bad++; $display("FAIL mask_release: ext=%b cause=%0d expected 1 0", bus.External_intr, bus.intr_cause);
        end
        pulse_ack(); pulse_eret(); tick();
    endtask

    task automatic test_svc_block();
        pulse_src(4'b0100);
        wait_req("svc");
        pulse_ack();
        pulse_src(4'b0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (bus.External_intr !== 1'b0) begin n_bad++; $display("FAIL svc_no_preempt: cycle %0d ext=%b expected 0", i, bus.External_intr); end
        end
        n_cmp++;
        if (bus.pending_q !== 4'b0001) begin n_bad++; $display("FAIL svc_pending: pend=%h expected 1", bus.pending_q); end
        pulse_eret();
        n_cmp++;
        if (bus.External_intr !== 1'b0) begin n_bad++; $display("FAIL svc_eret_gap: ext=%b expected 0", bus.External_intr); end
        tick();
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause} !== {1'b1, 2'd0}) begin
            n_bad++; $display("FAIL svc_after_eret: ext=%b cause=%0d expected 1 0", bus.External_intr, bus.intr_cause);
        end
        pulse_ack(); pulse_eret(); tick();
    endtask

    task automatic test_ack_edge();
        pulse_src(4'b0010);
        wait_req("ackedge");
        // Rise sampled two edges before the ack so its pending-set lands on the ack edge.
        bus.irq_src = 4'b0010; tick(); bus.irq_src = 4'b0000; tick();
        pulse_ack();
        n_cmp++;
        if ({bus.pending_q[1], bus.in_service} !== 2'b11) begin
            n_bad++; $display("FAIL ack_edge_set_wins: pend1=%b svc=%b expected 1 1", bus.pending_q[1], bus.in_service);
        end
        pulse_eret(); tick();
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause} !== {1'b1, 2'd1}) begin
            n_bad++; $display("FAIL ack_edge_rerequest: ext=%b cause=%0d expected 1 1", bus.External_intr, bus.intr_cause);
        end
        pulse_ack(); pulse_eret(); tick();
    endtask

    task automatic test_reset_mid();
        pulse_src(4'b1000);
        wait_req("rstreq");
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service} !== {1'b0, 2'd0, 4'hF, 4'h0, 1'b0}) begin
            n_bad++; $display("FAIL reset_in_req: ext=%b cause=%0d mask=%h pend=%h svc=%b expected 0 0 f 0 0",
                bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service);
        end
        pulse_src(4'b0100);
        wait_req("rstsvc");
        pulse_ack();
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b0011; tick(); bus.mask_we = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if ({bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service} !== {1'b0, 2'd0, 4'hF, 4'h0, 1'b0}) begin
            n_bad++; $display("FAIL reset_in_svc: ext=%b cause=%0d mask=%h pend=%h svc=%b expected 0 0 f 0 0",
                bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service);
        end
        pulse_ack(); pulse_eret(); tick(); tick();
        n_cmp++;
        if ({bus.External_intr, bus.in_service, bus.pending_q} !== {1'b0, 1'b0, 4'h0}) begin
            n_bad++; $display("FAIL stray_ack_eret: ext=%b svc=%b pend=%h expected 0 0 0", bus.External_intr, bus.in_service, bus.pending_q);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst            = ($urandom_range(0, 249) == 0);
            bus.irq_src    = bus.irq_src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            bus.intr_ack   = ($urandom_range(0, 3) == 0);
            bus.intr_eret  = ($urandom_range(0, 5) == 0);
            bus.mask_we    = ($urandom_range(0, 15) == 0);
            bus.mask_wdata = 4'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if ({bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service} !==
                {(m_mode == 1), 2'(m_cause), m_mask, m_pend, (m_mode == 2)}) begin
                n_bad++; $display("FAIL random_c%0d: ext=%b cause=%0d mask=%h pend=%h svc=%b expected %b %0d %h %h %b",
                    c, bus.External_intr, bus.intr_cause, bus.mask_q, bus.pending_q, bus.in_service,
                    (m_mode == 1), m_cause, m_mask, m_pend, (m_mode == 2));
            end
        end
        rst = 1'b0; bus.irq_src = 4'h0; bus.intr_ack = 1'b0; bus.intr_eret = 1'b0; bus.mask_we = 1'b0;
    endtask

    initial begin
        bus.irq_src = 4'h0; bus.mask_we = 1'b0; bus.mask_wdata = 4'h0;
        bus.intr_ack = 1'b0; bus.intr_eret = 1'b0;
        tick();
        test_reset();
        test_latency();
        test_priority();
        test_mask();
        test_svc_block();
        test_ack_edge();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
